// File: rtl/ysyx_24100005_wb_pkg.sv
// ysyx_24100005_wb_pkg
//   Shared types for the write-back arbiter: the buffered result entry and
//   the source encoding used by the round-robin pointer.
//   Ports: none (package).
package ysyx_24100005_wb_pkg;

    localparam int WB_ADDR_WIDTH = 5;
    localparam int WB_DATA_WIDTH = 32;

    // Source encoding; also the value held by the round-robin pointer.
    localparam logic SRC_EXU = 1'b0;
    localparam logic SRC_LSU = 1'b1;

    typedef struct packed {
        logic [WB_ADDR_WIDTH-1:0] rd;
        logic [WB_DATA_WIDTH-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/ysyx_24100005_wb_fifo.sv
// ysyx_24100005_wb_fifo
//   Small per-source result FIFO. Pointers carry one extra wrap bit so that
//   full and empty are distinguished without a separate counter.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset (empties the FIFO)
//     push, din    write din when push && !full
//     pop          drop the head when pop && !empty
//     full, empty  status, combinational from the pointers
//     head         oldest entry (undefined content while empty)
module ysyx_24100005_wb_fifo
    import ysyx_24100005_wb_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = wb_entry_t
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push,
    input  entry_t din,
    input  logic   pop,
    output logic   full,
    output logic   empty,
    output entry_t head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    entry_t      mem [DEPTH];

    logic do_push;
    logic do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // A full FIFO never accepts, even when its head leaves this same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/ysyx_24100005_wb_arbiter.sv
// ysyx_24100005_wb_arbiter
//   GPR write-port writer. EXU and LSU results are each buffered in their own
//   FIFO; one head per cycle is granted round-robin and issued as a registered
//   register-file write. Entries with rd==0 are popped without writing.
//   Optional feature macro: WB_BYPASS_EN adds a combinational forward of the
//   pending (registered, not yet committed) write onto two read ports.
//   Ports:
//     clk, rst_n                      clock, asynchronous active-low reset
//     exu_valid/ready/rd/data         EXU result handshake
//     lsu_valid/ready/rd/data         LSU result handshake
//     rf_wen/rf_waddr/rf_wdata        registered register-file write
//     busy                            any FIFO non-empty or write pending
//     rs1addr/rs2addr, rsNdata_rf,    (WB_BYPASS_EN) read-port forwarding
//     rsNdata_fwd
module ysyx_24100005_wb_arbiter
    import ysyx_24100005_wb_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  exu_valid,
    output logic                  exu_ready,
    input  logic [ADDR_WIDTH-1:0] exu_rd,
    input  logic [DATA_WIDTH-1:0] exu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  busy
`ifdef WB_BYPASS_EN
    ,
    input  logic [ADDR_WIDTH-1:0] rs1addr,
    input  logic [ADDR_WIDTH-1:0] rs2addr,
    input  logic [DATA_WIDTH-1:0] rs1data_rf,
    input  logic [DATA_WIDTH-1:0] rs2data_rf,
    output logic [DATA_WIDTH-1:0] rs1data_fwd,
    output logic [DATA_WIDTH-1:0] rs2data_fwd
`endif
);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    entry_t exu_head, lsu_head, head;
    logic   exu_full, exu_empty, lsu_full, lsu_empty;
    logic   rr_ptr;
    logic   grant_vld, grant_src;
    logic   pop_exu, pop_lsu;

    assign exu_ready = !exu_full;
    assign lsu_ready = !lsu_full;

    ysyx_24100005_wb_fifo #(.DEPTH(FIFO_DEPTH), .entry_t(entry_t)) u_exu_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (exu_valid),
        .din   ('{rd: exu_rd, data: exu_data}),
        .pop   (pop_exu),
        .full  (exu_full),
        .empty (exu_empty),
        .head  (exu_head)
    );

    ysyx_24100005_wb_fifo #(.DEPTH(FIFO_DEPTH), .entry_t(entry_t)) u_lsu_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (lsu_valid),
        .din   ('{rd: lsu_rd, data: lsu_data}),
        .pop   (pop_lsu),
        .full  (lsu_full),
        .empty (lsu_empty),
        .head  (lsu_head)
    );

    // Contended: rr_ptr decides. Otherwise whichever FIFO holds data wins.
    assign grant_vld = !exu_empty || !lsu_empty;
    assign grant_src = (!exu_empty && !lsu_empty) ? rr_ptr
                     : (exu_empty ? SRC_LSU : SRC_EXU);
    assign pop_exu   = grant_vld && (grant_src == SRC_EXU);
    assign pop_lsu   = grant_vld && (grant_src == SRC_LSU);
    assign head      = (grant_src == SRC_LSU) ? lsu_head : exu_head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr   <= SRC_EXU;
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_wen <= grant_vld && (head.rd != '0);
            if (grant_vld) begin
                // Pointer flips to the other source even when uncontended.
                rr_ptr <= ~grant_src;
                // rd==0 pops leave the address/data registers untouched.
                if (head.rd != '0) begin
                    rf_waddr <= head.rd;
                    rf_wdata <= head.data;
                end
            end
        end
    end

    assign busy = !exu_empty || !lsu_empty || rf_wen;

`ifdef WB_BYPASS_EN
    // Forward the registered write the regfile will only commit at the edge.
    assign rs1data_fwd = (rf_wen && rf_waddr == rs1addr && rs1addr != '0) ? rf_wdata : rs1data_rf;
    assign rs2data_fwd = (rf_wen && rf_waddr == rs2addr && rs2addr != '0) ? rf_wdata : rs2data_rf;
`endif

endmodule

// File: tb/tb_ysyx_24100005_wb_arbiter.sv
// Self-checking bench for ysyx_24100005_wb_arbiter. Accepted results are
// queued per source when the handshake is seen; every register-file write
// must match the head of one of those queues.
module tb_ysyx_24100005_wb_arbiter;
    import ysyx_24100005_wb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        exu_valid = 1'b0, lsu_valid = 1'b0;
    logic        exu_ready, lsu_ready;
    logic [4:0]  exu_rd = '0, lsu_rd = '0;
    logic [31:0] exu_data = '0, lsu_data = '0;
    logic        rf_wen, busy;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
`ifdef WB_BYPASS_EN
    logic [4:0]  rs1addr = '0, rs2addr = '0;
    logic [31:0] rs1data_rf = '0, rs2data_rf = '0;
    logic [31:0] rs1data_fwd, rs2data_fwd;
`endif

    int tests = 0;
    int fails = 0;
    wb_entry_t  exp_exu[$];
    wb_entry_t  exp_lsu[$];
    logic [4:0] wlog[$];

    always #5 clk = ~clk;

    ysyx_24100005_wb_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .FIFO_DEPTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .exu_valid (exu_valid),
        .exu_ready (exu_ready),
        .exu_rd    (exu_rd),
        .exu_data  (exu_data),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_rd    (lsu_rd),
        .lsu_data  (lsu_data),
        .rf_wen    (rf_wen),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .busy      (busy)
`ifdef WB_BYPASS_EN
        ,
        .rs1addr     (rs1addr),
        .rs2addr     (rs2addr),
        .rs1data_rf  (rs1data_rf),
        .rs2data_rf  (rs2data_rf),
        .rs1data_fwd (rs1data_fwd),
        .rs2data_fwd (rs2data_fwd)
`endif
    );

    // Scoreboard monitor: each write must be the oldest outstanding entry of
    // one source.
    always @(negedge clk) begin
        if (rst_n && rf_wen) begin
            tests++;
            wlog.push_back(rf_waddr);
            if (exp_exu.size() > 0 && exp_exu[0].rd == rf_waddr && exp_exu[0].data == rf_wdata)
                void'(exp_exu.pop_front());
            else if (exp_lsu.size() > 0 && exp_lsu[0].rd == rf_waddr && exp_lsu[0].data == rf_wdata)
                void'(exp_lsu.pop_front());
            else begin
                fails++;
                $display("FAIL write_match: got rd=%0d data=%h, not at head of exu_q(%0d) or lsu_q(%0d)",
                         rf_waddr, rf_wdata, exp_exu.size(), exp_lsu.size());
            end
        end
    end

    // One cycle of stimulus, called at posedge+1; returns at the next posedge+1.
    task automatic drive(input logic ev, input logic [4:0] erd, input logic [31:0] ed,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                         output logic eacc, output logic lacc);
        exu_valid = ev; exu_rd = erd; exu_data = ed;
        lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
        @(negedge clk);
        eacc = ev && exu_ready;
        lacc = lv && lsu_ready;
        if (eacc && erd != 5'd0) exp_exu.push_back('{rd: erd, data: ed});
        if (lacc && lrd != 5'd0) exp_lsu.push_back('{rd: lrd, data: ld});
        @(posedge clk); #1;
        exu_valid = 1'b0;
        lsu_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        exp_exu.delete();
        exp_lsu.delete();
        wlog.delete();
    endtask

    task automatic check_drained(input string name);
        tests++;
        if (exp_exu.size() != 0 || exp_lsu.size() != 0) begin
            fails++;
            $display("FAIL %s_drain: outstanding exu=%0d lsu=%0d, required 0 and 0",
                     name, exp_exu.size(), exp_lsu.size());
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        tests++; if (rf_wen !== 1'b0)      begin fails++; $display("FAIL reset_wen: got %b want 0", rf_wen); end
        tests++; if (rf_waddr !== 5'd0)    begin fails++; $display("FAIL reset_waddr: got %0d want 0", rf_waddr); end
        tests++; if (rf_wdata !== 32'd0)   begin fails++; $display("FAIL reset_wdata: got %h want 0", rf_wdata); end
        tests++; if (exu_ready !== 1'b1)   begin fails++; $display("FAIL reset_exu_ready: got %b want 1", exu_ready); end
        tests++; if (lsu_ready !== 1'b1)   begin fails++; $display("FAIL reset_lsu_ready: got %b want 1", lsu_ready); end
        tests++; if (busy !== 1'b0)        begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_single();
        logic ea, la;
        do_reset();
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, ea, la);
        @(negedge clk);
        tests++; if (rf_wen !== 1'b0) begin fails++; $display("FAIL single_t1_wen: got %b want 0", rf_wen); end
        @(posedge clk); #1; @(negedge clk);
        tests++; if (rf_wen !== 1'b1) begin fails++; $display("FAIL single_t2_wen: got %b want 1", rf_wen); end
        tests++; if (rf_waddr !== 5'd5) begin fails++; $display("FAIL single_t2_waddr: got %0d want 5", rf_waddr); end
        tests++; if (rf_wdata !== 32'hDEADBEEF) begin fails++; $display("FAIL single_t2_wdata: got %h want deadbeef", rf_wdata); end
        @(posedge clk); #1; @(negedge clk);
        tests++; if (rf_wen !== 1'b0) begin fails++; $display("FAIL single_t3_wen: got %b want 0", rf_wen); end
        @(posedge clk); #1;
        check_drained("single");
    endtask

    task automatic test_back_to_back();
        logic ea, la;
        int ei = 0, li = 0, cyc = 0, e_low = 0, l_low = 0;
        logic [4:0] want [8] = '{5'd1, 5'd9, 5'd2, 5'd10, 5'd3, 5'd11, 5'd4, 5'd12};
        do_reset();
        while ((ei < 4 || li < 4) && cyc < 20) begin
            drive(ei < 4, 5'(1 + ei), 32'h1000 + ei, li < 4, 5'(9 + li), 32'h2000 + li, ea, la);
            if (ei < 4 && !ea) e_low++;
            if (li < 4 && !la) l_low++;
            if (ea) ei++;
            if (la) li++;
            cyc++;
        end
        tests++; if (cyc >= 20) begin fails++; $display("FAIL b2b_timeout: pushed exu=%0d lsu=%0d want 4 and 4", ei, li); end
        idle(8);
        tests++; if (e_low == 0) begin fails++; $display("FAIL b2b_exu_ready_drop: stalls %0d, want >0", e_low); end
        tests++; if (l_low == 0) begin fails++; $display("FAIL b2b_lsu_ready_drop: stalls %0d, want >0", l_low); end
        tests++;
        if (wlog.size() != 8) begin
            fails++; $display("FAIL b2b_count: got %0d writes want 8", wlog.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                tests++;
                if (wlog[i] !== want[i]) begin
                    fails++; $display("FAIL b2b_order[%0d]: got rd=%0d want rd=%0d", i, wlog[i], want[i]);
                end
            end
        end
        check_drained("b2b");
    endtask

    task automatic test_full();
        logic ea, la;
        int ei = 0, li = 0;
        logic want_e [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic want_l [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        do_reset();
        for (int c = 0; c < 8; c++) begin
            drive(1'b1, 5'(1 + ei % 15), 32'h3000 + ei, 1'b1, 5'(16 + li % 15), 32'h4000 + li, ea, la);
            tests++; if (ea !== want_e[c]) begin fails++; $display("FAIL full_exu_ready[c%0d]: got %b want %b", c, ea, want_e[c]); end
            tests++; if (la !== want_l[c]) begin fails++; $display("FAIL full_lsu_ready[c%0d]: got %b want %b", c, la, want_l[c]); end
            if (ea) ei++;
            if (la) li++;
        end
        idle(8);
        check_drained("full");
    endtask

    task automatic test_rd_zero();
        logic ea, la;
        do_reset();
        drive(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'd0, ea, la);
        @(negedge clk);
        tests++; if (rf_wen !== 1'b0) begin fails++; $display("FAIL rd0_t1_wen: got %b want 0", rf_wen); end
        tests++; if (busy !== 1'b1)   begin fails++; $display("FAIL rd0_t1_busy: got %b want 1", busy); end
        @(posedge clk); #1; @(negedge clk);
        tests++; if (rf_wen !== 1'b0) begin fails++; $display("FAIL rd0_t2_wen: got %b want 0", rf_wen); end
        tests++; if (busy !== 1'b0)   begin fails++; $display("FAIL rd0_t2_busy: got %b want 0", busy); end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic ea, la;
        logic pe_v = 1'b0, pl_v = 1'b0;
        wb_entry_t pe, pl;
        int pushed = 0, cyc = 0;
        do_reset();
        pe = '0; pl = '0;
        while (pushed < 1000 && cyc < 5000) begin
            if (!pe_v && $urandom_range(0, 3) != 0) begin
                pe.rd = 5'($urandom_range(0, 31)); pe.data = $urandom; pe_v = 1'b1;
            end
            if (!pl_v && $urandom_range(0, 3) != 0) begin
                pl.rd = 5'($urandom_range(0, 31)); pl.data = $urandom; pl_v = 1'b1;
            end
            drive(pe_v, pe.rd, pe.data, pl_v, pl.rd, pl.data, ea, la);
            if (ea) begin pe_v = 1'b0; pushed++; end
            if (la) begin pl_v = 1'b0; pushed++; end
            cyc++;
        end
        tests++; if (pushed < 1000) begin fails++; $display("FAIL random_progress: pushed %0d want 1000", pushed); end
        for (int i = 0; i < 20 && (exp_exu.size() != 0 || exp_lsu.size() != 0 || busy); i++) idle(1);
        check_drained("random");
    endtask

    task automatic test_reset_mid();
        logic ea, la;
        do_reset();
        drive(1'b1, 5'd3, 32'hA, 1'b1, 5'd20, 32'hB, ea, la);
        drive(1'b1, 5'd4, 32'hC, 1'b1, 5'd21, 32'hD, ea, la);
        #2 rst_n = 1'b0;
        #1;
        tests++; if (rf_wen !== 1'b0) begin fails++; $display("FAIL rstmid_wen: got %b want 0", rf_wen); end
        tests++; if (busy !== 1'b0)   begin fails++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        exp_exu.delete();
        exp_lsu.delete();
        wlog.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        #1;
        tests++; if (exu_ready !== 1'b1) begin fails++; $display("FAIL rstmid_exu_ready: got %b want 1", exu_ready); end
        tests++; if (lsu_ready !== 1'b1) begin fails++; $display("FAIL rstmid_lsu_ready: got %b want 1", lsu_ready); end
        idle(6);
        tests++; if (wlog.size() != 0) begin fails++; $display("FAIL rstmid_stale: got %0d writes want 0", wlog.size()); end
    endtask

`ifdef WB_BYPASS_EN
    task automatic test_bypass();
        logic ea, la;
        do_reset();
        rs1addr = 5'd7; rs1data_rf = 32'h11;
        rs2addr = 5'd0; rs2data_rf = 32'h22;
        drive(1'b1, 5'd7, 32'hA5, 1'b0, 5'd0, 32'd0, ea, la);
        @(posedge clk); #1; @(negedge clk);
        tests++; if (rs1data_fwd !== 32'hA5) begin fails++; $display("FAIL bypass_rs1: got %h want a5", rs1data_fwd); end
        tests++; if (rs2data_fwd !== 32'h22) begin fails++; $display("FAIL bypass_rs2: got %h want 22", rs2data_fwd); end
        @(posedge clk); #1; @(negedge clk);
        tests++; if (rs1data_fwd !== 32'h11) begin fails++; $display("FAIL bypass_rs1_idle: got %h want 11", rs1data_fwd); end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_rd_zero();
        test_random();
        test_reset_mid();
`ifdef WB_BYPASS_EN
        test_bypass();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
